// File: rtl/sobol_seq_ctrl.sv
// sobol_seq_ctrl: walks (path, dim) indices in path-major order into a combinational
// Sobol core and registers each result onto a valid/ready stream. Macro SOBOL_SKIP_ZERO_EN starts at path 1.
module sobol_seq_ctrl #(
  parameter int M  = 50,
  parameter int PW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PW-1:0]        num_paths,
  output logic [31:0]          sob_n,
  output logic [$clog2(M)-1:0] sob_dim,
  input  logic [31:0]          sob_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [PW-1:0]        out_path,
  output logic [$clog2(M)-1:0] out_dim,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int DW = $clog2(M);
`ifdef SOBOL_SKIP_ZERO_EN
  localparam logic [PW:0] P0 = (PW+1)'(1);
`else
  localparam logic [PW:0] P0 = '0;
`endif
  localparam logic [DW-1:0] DIM_LAST = DW'(M-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  // One bit wider than num_paths so the post-final increment to P0+num_paths cannot wrap.
  logic [PW:0]   path_q;
  logic [PW:0]   last_path_q;
  logic [PW:0]   last_path_calc;
  logic [DW-1:0] dim_q;
  logic          exhausted_q;
  logic          load;
  logic          accept;
  logic          is_final;

  assign last_path_calc = P0 + {1'b0, num_paths} - (PW+1)'(1);
  assign is_final       = (path_q == last_path_q) && (dim_q == DIM_LAST);
  assign load           = (state == RUN) && !exhausted_q && (!out_valid || out_ready);
  assign accept         = out_valid && out_ready;

  assign sob_dim = dim_q;
  generate
    if (PW >= 32) begin : g_n_trunc
      assign sob_n = path_q[31:0];
    end else begin : g_n_ext
      assign sob_n = {{(32-PW){1'b0}}, path_q[PW-1:0]};
    end
  endgenerate

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path through the block infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_paths == '0) ? DONE : RUN;
      end
      RUN: begin
        if (abort)                  state_nxt = IDLE;
        else if (accept && out_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      path_q      <= P0;
      last_path_q <= P0;
      dim_q       <= '0;
      exhausted_q <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_path    <= '0;
      out_dim     <= '0;
      out_last    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        path_q      <= P0;
        dim_q       <= '0;
        exhausted_q <= 1'b0;
        last_path_q <= last_path_calc;
      end

      if (state == RUN) begin
        if (abort) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else if (load) begin
          out_valid <= 1'b1;
          out_data  <= sob_value;
          out_path  <= path_q[PW-1:0];
          out_dim   <= dim_q;
          out_last  <= is_final;
          if (is_final) exhausted_q <= 1'b1;
          if (dim_q == DIM_LAST) begin
            dim_q  <= '0;
            path_q <= path_q + (PW+1)'(1);
          end else begin
            dim_q  <= dim_q + DW'(1);
          end
        end else if (accept) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
